impulse_mac: RTL
================

# impulse_mac

Accumulation stage downstream of the memory controller in the convolution reverb/delay path. Consumes the interleaved stream of impulse-descriptor words and delayed-sample words that the controller reads from SRAM or off-chip memory. For each tap, it decodes the descriptor, multiplies the sample by the tap gain and adds or subtracts the product into a wide accumulator. Once per ADC frame it emits one saturated 16-bit wet+dry sample to the output/DAC stage.

## Interface
- MAX_IMPULSES, 500: maximum taps per frame; sizes the tap counter (11 bits).
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- frame_start  in  1  one-cycle pulse per ADC sample, synchronous to clk; begins a frame.
- impulses  in  11  tap count for the frame, sampled on frame_start, range 0..MAX_IMPULSES.
- dry_in  in  16  signed dry sample, sampled on frame_start.
- mem_valid  in  1  mem_data holds a read word.
- mem_is_impulse  in  1  tag: 1 = descriptor word, 0 = sample word.
- mem_data  in  16  read word from the memory controller.
- mem_ready  out  1  block accepts a word this cycle. A transfer occurs when mem_valid and mem_ready are both high.
- offset  out  7  decoded tap address offset {mem_data[15:13], mem_data[12:9]}.
- offset_valid  out  1  one-cycle pulse when offset updates.
- out_sample  out  16  signed frame result.
- out_valid  out  1  one-cycle pulse with out_sample.
- busy  out  1  high in any state except IDLE.
- proto_err  out  1  sticky; set on a tag mismatch.
- overrun  out  1  sticky; set when frame_start arrives while busy.
- All outputs reset to 0.

## Operation
- Descriptor fields:
  - [15:13] top offset
  - [12:9] bottom offset
  - [8] negate
  - [7:0] unsigned multiplier, gain = m/256
- States and transitions:
  - IDLE --frame_start--> WAIT_IMP if impulses != 0, else DONE.
  - WAIT_IMP --descriptor accepted--> WAIT_SMP.
  - WAIT_SMP --sample accepted--> ACC.
  - ACC --> WAIT_IMP if taps remain, else DONE.
  - DONE --> IDLE.
- On frame_start: acc <= sign_ext(dry_in) <<< 8; tap_cnt <= 0.
- mem_ready is high only in WAIT_IMP and WAIT_SMP.
- On descriptor accept: latch negate and multiplier; register offset; pulse offset_valid.
- On sample accept: prod <= signed(mem_data) * {1'b0, mult}. prod is 25-bit signed and registered.
- ACC: acc <= acc ± prod; tap_cnt++.
- Accumulator width ACC_W = 36. This cannot overflow for 500 full-scale taps.
- DONE: out_sample <= saturate(acc >>> 8) to [-32768, 32767]; out_valid pulses.
- Tag mismatch: the accepted word carries the wrong mem_is_impulse for the current state.
  - The word is dropped and the state is unchanged.
  - proto_err is set.
- frame_start while busy:
  - overrun is set.
  - The in-flight frame is discarded; no out_valid is issued for it.
  - The new frame starts exactly as it would from IDLE.
- A multiplier of 0 contributes 0, but the tap still consumes both of its words.
- rst mid-frame returns the block to IDLE and clears acc, tap_cnt and all outputs, including both sticky flags.

## Timing
- Descriptor accepted at edge E: offset and offset_valid are visible after E, for one cycle.
- Last sample accepted at edge E:
  - prod registered at E.
  - acc updated at E+1.
  - out_sample and out_valid registered at E+2.
- impulses = 0 with frame_start sampled at edge F: out_valid is high after F+1.
- Minimum per-tap throughput is 3 cycles: descriptor, sample, ACC. mem_ready is low during ACC.
- Frame budget: impulses×3 + 3 cycles, which must fit within the ADC period.

## Structure
- Package pedal_mac_pkg holds:
  - the state enum
  - ACC_W
  - descriptor field positions and widths
  - OFFSET_W = 7
  - the saturation limits
- One sub-module, mac_datapath, holds:
  - the product register
  - the add/subtract into the accumulator
  - the saturating 16-bit output
- The top level holds the FSM, the tap counter and the handshake logic.

## Test plan
- impulses=0, dry_in=0x1234, frame_start -> one out_valid pulse at F+1, out_sample=0x1234, no mem_ready.
- impulses=1, dry=0, descriptor 0x4A80 then sample 0x1000 -> offset=0x25 with offset_valid pulse; out_sample=0x0800 two edges after the sample.
- Same frame with descriptor 0x4B80 (negate set) -> out_sample=0xF800.
- dry=0x7000, two taps with descriptor 0x00FF and sample 0x7FFF -> out_sample=0x7FFF (positive saturation). All-negative equivalent -> 0x8000.
- Sample word presented in WAIT_IMP -> dropped, proto_err=1; the frame then completes with the correct value.
- frame_start during WAIT_SMP -> overrun=1, no out_valid for the old frame, correct result for the new frame; rst asserted mid-frame -> all outputs 0 and busy=0 immediately.

Source files
------------

// File: rtl/pedal_mac_pkg.sv
// Shared types and constants for the impulse accumulation stage.
package pedal_mac_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_WAIT_IMP = 3'd1,
      S_WAIT_SMP = 3'd2,
      S_ACC      = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   localparam int MAX_IMPULSES = 500;
   localparam int TAP_W        = 11;
   localparam int ACC_W        = 36;
   localparam int PROD_W       = 25;
   localparam int SAMPLE_W     = 16;
   localparam int OFFSET_W     = 7;
   localparam int DRY_SHIFT    = 8;

   // Descriptor word layout
   localparam int DESC_TOP_MSB  = 15;
   localparam int DESC_TOP_LSB  = 13;
   localparam int DESC_BOT_MSB  = 12;
   localparam int DESC_BOT_LSB  = 9;
   localparam int DESC_NEG_BIT  = 8;
   localparam int DESC_MULT_MSB = 7;
   localparam int MULT_W        = 8;

   localparam logic signed [ACC_W-1:0] SAT_MAX = 36'sd32767;
   localparam logic signed [ACC_W-1:0] SAT_MIN = -36'sd32768;

   // Clamp a scaled accumulator value into the signed 16-bit output range.
   function automatic logic [SAMPLE_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
      if (v > SAT_MAX)
         return 16'h7FFF;
      else if (v < SAT_MIN)
         return 16'h8000;
      else
         return v[SAMPLE_W-1:0];
   endfunction

endpackage

// File: rtl/mac_datapath.sv
// Product register, signed accumulator and saturating output stage.
module mac_datapath
   import pedal_mac_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [SAMPLE_W-1:0] dry,
   input  logic                smp_load,
   input  logic [SAMPLE_W-1:0] sample,
   input  logic [MULT_W-1:0]   mult,
   input  logic                negate,
   input  logic                acc_en,
   input  logic                out_en,
   output logic [SAMPLE_W-1:0] out_sample,
   output logic                out_valid
);

   logic signed [PROD_W-1:0] prod;
   logic signed [PROD_W-1:0] smp_ext;
   logic signed [PROD_W-1:0] mult_ext;
   logic signed [ACC_W-1:0]  acc;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  acc_scaled;
   logic signed [ACC_W-1:0]  dry_ext;

   // Operands widened to the product width so the 25-bit multiply is exact.
   assign smp_ext    = {{(PROD_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};
   assign mult_ext   = {{(PROD_W-MULT_W){1'b0}}, mult};
   assign prod_ext   = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
   assign dry_ext    = {{(ACC_W-SAMPLE_W-DRY_SHIFT){dry[SAMPLE_W-1]}}, dry, {DRY_SHIFT{1'b0}}};
   assign acc_scaled = acc >>> DRY_SHIFT;

   // Register the tap product when its sample word is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         prod <= '0;
      else if (smp_load)
         prod <= smp_ext * mult_ext;
   end

   // Seed with the dry sample at frame start, then add or subtract each tap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         acc <= '0;
      else if (load)
         acc <= dry_ext;
      else if (acc_en)
         acc <= negate ? (acc - prod_ext) : (acc + prod_ext);
   end

   // Saturated frame result with a single-cycle valid strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_sample <= '0;
         out_valid  <= 1'b0;
      end else begin
         out_valid <= out_en;
         if (out_en)
            out_sample <= sat16(acc_scaled);
      end
   end

endmodule

// File: rtl/impulse_mac.sv
// Convolution tap accumulator: sequences descriptor/sample word pairs into the MAC.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | no frame in progress
// WAIT_IMP | waiting for the next tap descriptor word
// WAIT_SMP | waiting for the delayed sample word of the tap
// ACC      | folding the registered product into acc
// DONE     | emitting the saturated frame result
module impulse_mac
   import pedal_mac_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_start,
   input  logic [TAP_W-1:0]    impulses,
   input  logic [SAMPLE_W-1:0] dry_in,
   input  logic                mem_valid,
   input  logic                mem_is_impulse,
   input  logic [SAMPLE_W-1:0] mem_data,
   output logic                mem_ready,
   output logic [OFFSET_W-1:0] offset,
   output logic                offset_valid,
   output logic [SAMPLE_W-1:0] out_sample,
   output logic                out_valid,
   output logic                busy,
   output logic                proto_err,
   output logic                overrun
);

   state_t             state, state_n;
   logic [TAP_W-1:0]   tap_cnt;
   logic [TAP_W-1:0]   n_taps;
   logic [MULT_W-1:0]  mult;
   logic               negate;
   logic               xfer, desc_ok, smp_ok, tag_err, last_tap;
   logic               acc_en, out_en;

   // A frame_start wins over any word presented in the same cycle.
   assign xfer     = mem_valid & mem_ready & ~frame_start;
   assign desc_ok  = xfer && (state == S_WAIT_IMP) &&  mem_is_impulse;
   assign smp_ok   = xfer && (state == S_WAIT_SMP) && !mem_is_impulse;
   assign tag_err  = xfer && (((state == S_WAIT_IMP) && !mem_is_impulse) ||
                              ((state == S_WAIT_SMP) &&  mem_is_impulse));
   assign last_tap = ((tap_cnt + TAP_W'(1)) == n_taps);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_IDLE;
      else
         state <= state_n;
   end

   // Next-state logic; a new frame restarts from any state.
   always_comb begin
      state_n = state;
      if (frame_start) begin
         state_n = (impulses != '0) ? S_WAIT_IMP : S_DONE;
      end else begin
         case (state)
            S_IDLE:     state_n = S_IDLE;
            S_WAIT_IMP: if (desc_ok) state_n = S_WAIT_SMP;
            S_WAIT_SMP: if (smp_ok)  state_n = S_ACC;
            S_ACC:      state_n = last_tap ? S_DONE : S_WAIT_IMP;
            S_DONE:     state_n = S_IDLE;
            default:    state_n = S_IDLE;
         endcase
      end
   end

   // Handshake and datapath strobes decoded from the current state.
   always_comb begin
      mem_ready = (state == S_WAIT_IMP) || (state == S_WAIT_SMP);
      busy      = (state != S_IDLE);
      acc_en    = (state == S_ACC)  && !frame_start;
      out_en    = (state == S_DONE) && !frame_start;
   end

   // Tap counter, descriptor latch and sticky error flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tap_cnt      <= '0;
         n_taps       <= '0;
         mult         <= '0;
         negate       <= 1'b0;
         offset       <= '0;
         offset_valid <= 1'b0;
         proto_err    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         offset_valid <= 1'b0;
         if (frame_start) begin
            tap_cnt <= '0;
            n_taps  <= impulses;
            if (state != S_IDLE)
               overrun <= 1'b1;
         end else if (acc_en) begin
            tap_cnt <= tap_cnt + TAP_W'(1);
         end
         if (desc_ok) begin
            negate       <= mem_data[DESC_NEG_BIT];
            mult         <= mem_data[DESC_MULT_MSB:0];
            offset       <= {mem_data[DESC_TOP_MSB:DESC_TOP_LSB],
                             mem_data[DESC_BOT_MSB:DESC_BOT_LSB]};
            offset_valid <= 1'b1;
         end
         if (tag_err)
            proto_err <= 1'b1;
      end
   end

   mac_datapath u_dp (
      .clk        (clk),
      .rst        (rst),
      .load       (frame_start),
      .dry        (dry_in),
      .smp_load   (smp_ok),
      .sample     (mem_data),
      .mult       (mult),
      .negate     (negate),
      .acc_en     (acc_en),
      .out_en     (out_en),
      .out_sample (out_sample),
      .out_valid  (out_valid)
   );

endmodule
